// File: rtl/scratchpad_mem_if.sv
// Request/response bundle between scratchpad_mem and its two clients:
// the host (sc_*) and the systolic array (arr_*).
interface scratchpad_mem_if;
  // Host side
  logic        sc_read_en;
  logic        sc_write_en;
  logic [31:0] sc_addr;
  logic [31:0] sc_data_in;
  logic [31:0] sc_data_out;
  logic        sc_ready;
  // Array side
  logic        arr_req;
  logic        arr_we;
  logic [31:0] arr_addr;
  logic [31:0] arr_wdata;
  logic [31:0] arr_rdata;
  logic        arr_ack;
  // Shared status
  logic        sc_err;
  logic        busy;

  modport slave (
    input  sc_read_en, sc_write_en, sc_addr, sc_data_in,
    input  arr_req, arr_we, arr_addr, arr_wdata,
    output sc_data_out, sc_ready, arr_rdata, arr_ack, sc_err, busy
  );

  modport master (
    output sc_read_en, sc_write_en, sc_addr, sc_data_in,
    output arr_req, arr_we, arr_addr, arr_wdata,
    input  sc_data_out, sc_ready, arr_rdata, arr_ack, sc_err, busy
  );
endinterface

// File: rtl/scratchpad_mem.sv
// Word scratchpad shared by the host and the systolic array. One access at a time:
// IDLE accepts a request (round-robin on contention), ACCESS waits LATENCY cycles and
// performs the array access in its last cycle, DONE pulses the owning port's completion.
// Optional feature: define SCPAD_PARITY_EN to store one even-parity bit per word and
// flag parity mismatches on reads through sc_err.
module scratchpad_mem #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input logic               clk,
  input logic               rst,
  scratchpad_mem_if.slave   bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e              r_state;
  logic [3:0]          r_cnt;
  logic                r_last_arr;   // last grant went to the array
  logic                r_port_arr;   // in-flight access belongs to the array
  logic                r_we;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_sc_data_out;
  logic [31:0]         r_arr_rdata;
  logic                r_sc_ready;
  logic                r_arr_ack;
  logic                r_err;
  logic                r_busy;
  logic [31:0]         r_mem [DEPTH];

  logic                w_sc_req;
  logic                w_grant_sc;
  logic                w_grant_arr;
  logic                w_last;
  logic                w_oor;
  logic [ADDR_W-1:0]   w_idx;
  logic                w_mem_we;
  logic [31:0]         w_rd_data;
  logic                w_par_err;

  // A simultaneous read+write from the host counts as a single write request.
  assign w_sc_req    = bus.sc_read_en | bus.sc_write_en;
  assign w_grant_sc  = w_sc_req & (~bus.arr_req | r_last_arr);
  assign w_grant_arr = bus.arr_req & (~w_sc_req | ~r_last_arr);

  assign w_last    = (r_state == StAccess) && (r_cnt == 4'(LATENCY - 1));
  assign w_oor     = |r_addr[31:ADDR_W];
  assign w_idx     = r_addr[ADDR_W-1:0];
  assign w_mem_we  = w_last & r_we & ~w_oor;
  assign w_rd_data = w_oor ? 32'h0 : r_mem[w_idx];

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_idx] <= r_wdata;
  end

`ifdef SCPAD_PARITY_EN
  logic r_par [DEPTH];

  // Parity store: cleared on reset, written alongside the data word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_par[i] <= 1'b0;
    end else if (w_mem_we) begin
      r_par[w_idx] <= ^r_wdata;
    end
  end

  assign w_par_err = ~r_we & ~w_oor & ((^r_mem[w_idx]) != r_par[w_idx]);
`else
  assign w_par_err = 1'b0;
`endif

  // Access FSM with arbitration, request latching and registered completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_last_arr    <= 1'b1;
      r_port_arr    <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_sc_data_out <= '0;
      r_arr_rdata   <= '0;
      r_sc_ready    <= 1'b0;
      r_arr_ack     <= 1'b0;
      r_err         <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_sc_ready <= 1'b0;
      r_arr_ack  <= 1'b0;
      r_err      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_grant_sc || w_grant_arr) begin
            r_state    <= StAccess;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_port_arr <= w_grant_arr;
            r_last_arr <= w_grant_arr;
            r_we       <= w_grant_arr ? bus.arr_we    : bus.sc_write_en;
            r_addr     <= w_grant_arr ? bus.arr_addr  : bus.sc_addr;
            r_wdata    <= w_grant_arr ? bus.arr_wdata : bus.sc_data_in;
          end
        end
        StAccess: begin
          if (w_last) begin
            r_state <= StDone;
            r_err   <= w_oor | w_par_err;
            if (r_port_arr) r_arr_ack  <= 1'b1;
            else            r_sc_ready <= 1'b1;
            if (!r_we) begin
              if (r_port_arr) r_arr_rdata   <= w_rd_data;
              else            r_sc_data_out <= w_rd_data;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.sc_data_out = r_sc_data_out;
  assign bus.sc_ready    = r_sc_ready;
  assign bus.arr_rdata   = r_arr_rdata;
  assign bus.arr_ack     = r_arr_ack;
  assign bus.sc_err      = r_err;
  assign bus.busy        = r_busy;

endmodule
